addsub_arbiter: RTL and testbench

Controller that shares one WIDTH-bit ripple add/subtract datapath (half/full adder chain, two's-complement subtract) between two requesters. It arbitrates round-robin, latches the winner's operands, runs one add or subtract, registers sum, carry-out and zero flag, and returns a one-cycle done pulse to the winner. It sits between the adder chain and the two client blocks that previously drove the adder directly.

---
 rtl/addsub_arbiter.sv | 115 +++++++++++
 tb/tb_addsub_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared ripple add/subtract datapath.
// One operation per grant: operands latched on grant, result and flags registered one cycle later.
//
// state | meaning
// IDLE  | waiting for req0/req1; arbitrates and grants on the same edge
// EXEC  | latched operands drive the adder chain; result captured on exit
// RESP  | done pulse to the winner; pointer updated for the next tie
module addsub_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             win;
  logic             last;
  logic             pick1;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  // last = requester that won most recently; on a tie the other one goes
  assign pick1 = req1 & (~req0 | ~last);

  // subtract is a + ~b + 1: invert b and feed op in as the carry-in
  assign bx = b_r ^ {WIDTH{op_r}};

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = op_r;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a_r[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a_r[i] & bx[i]) | (c[i] & (a_r[i] ^ bx[i]));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_r  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      win   <= 1'b0;
      last  <= 1'b1;
      s     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            win   <= pick1;
            op_r  <= pick1 ? op1 : op0;
            a_r   <= pick1 ? a1 : a0;
            b_r   <= pick1 ? b1 : b0;
            gnt0  <= ~pick1;
            gnt1  <= pick1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          s     <= sum;
          cout  <= c[WIDTH];
          zero  <= (sum == '0);
          done0 <= ~win;
          done1 <= win;
          state <= RESP;
        end
        RESP: begin
          last  <= win;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: single ops, borrow/wrap cases, tie fairness,
// reset during an operation and result hold with idle ports.
module tb_addsub_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [5:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, done0, done1, cout, zero, busy;
  logic [5:0] s;

  int tests  = 0;
  int failed = 0;

  addsub_arbiter #(.WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .s(s), .cout(cout), .zero(zero), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One request from requester r, checked through grant, done and return to idle.
  task automatic run_op(input int r, input logic op, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] es, input logic ec, input logic ez, input string tag);
    @(negedge clock);
    if (r == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    tick();
    chk({tag, "_gnt"}, {gnt0, gnt1, done0, done1, busy}, {r == 0, r == 1, 1'b0, 1'b0, 1'b1});
    @(negedge clock);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk({tag, "_done"}, {gnt0, gnt1, done0, done1, busy}, {1'b0, 1'b0, r == 0, r == 1, 1'b1});
    chk({tag, "_res"}, {s, cout, zero}, {es, ec, ez});
    tick();
    chk({tag, "_idle"}, {gnt0, gnt1, done0, done1, busy}, 5'b0);
  endtask

  initial begin
    #2;
    chk("reset_outs", {s, cout, zero, gnt0, gnt1, done0, done1, busy}, 14'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    run_op(0, 1'b0, 6'd45, 6'd18, 6'd63, 1'b0, 1'b0, "add45_18");
    run_op(1, 1'b1, 6'd45, 6'd45, 6'd0,  1'b1, 1'b1, "sub_zero");
    run_op(1, 1'b1, 6'd5,  6'd9,  6'd60, 1'b0, 1'b0, "sub_borrow");
    run_op(0, 1'b0, 6'd63, 6'd1,  6'd0,  1'b1, 1'b1, "add_wrap");
    run_op(0, 1'b0, 6'd45, 6'd18, 6'd63, 1'b0, 1'b0, "add_again");

    // Port operands churn while no request is pending; result must hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      a0 = 6'(i * 7 + 3);
      b0 = 6'(i * 11 + 5);
      tick();
      chk("hold", {s, busy, gnt0, gnt1}, {6'd63, 3'b000});
    end

    // Reset during EXEC: outputs clear before the next edge, no done follows.
    @(negedge clock);
    req0 = 1'b1; op0 = 1'b0; a0 = 6'd45; b0 = 6'd18;
    tick();
    chk("rst_mid_gnt", {gnt0, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {s, cout, zero, gnt0, gnt1, done0, done1, busy}, 14'b0);
    req0 = 1'b0;
    tick();
    chk("rst_mid_nodone", {done0, done1, busy}, 3'b0);
    @(negedge clock);
    req1 = 1'b1; op1 = 1'b0; a1 = 6'd1; b1 = 6'd2;
    reset = 1'b0;
    tick();
    chk("rst_req1_gnt", {gnt0, gnt1}, 2'b01);
    @(negedge clock);
    req1 = 1'b0;
    tick();
    chk("rst_req1_res", {done1, s, cout, zero}, {1'b1, 6'd3, 1'b0, 1'b0});
    tick();

    // Tie from reset release: pointer reset favours 0, then strict alternation.
    @(negedge clock);
    reset = 1'b1;
    req0 = 1'b1; op0 = 1'b0; a0 = 6'd10; b0 = 6'd20;
    req1 = 1'b1; op1 = 1'b1; a1 = 6'd50; b1 = 6'd7;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      int turn;
      tick();
      turn = (c / 3) % 2;
      case (c % 3)
        0: chk("tie_gnt", {gnt0, gnt1, done0, done1}, {turn == 0, turn == 1, 2'b00});
        1: begin
          chk("tie_done", {gnt0, gnt1, done0, done1}, {2'b00, turn == 0, turn == 1});
          if (turn == 0) chk("tie_res0", {s, cout, zero}, {6'd30, 1'b0, 1'b0});
          else           chk("tie_res1", {s, cout, zero}, {6'd43, 1'b1, 1'b0});
        end
        default: chk("tie_idle", {gnt0, gnt1, done0, done1, busy}, 5'b0);
      endcase
    end
    req0 = 1'b0;
    req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
